// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: transmit mailbox scheduler in front of can_tx.
// Picks the pending frame with the lowest ID (ties go to the lowest mailbox index),
// launches it, and re-queues it on arbitration loss or bus error.
// Optional feature macro: CAN_TXSCHED_RETRY_LIMIT_EN. When it is defined, a frame is
// aborted after MAX_RETRY failed attempts. When it is undefined, retries are unlimited
// and mb_abort is tied low.
module can_tx_scheduler #(
   parameter int NUM_MB    = 4,
   parameter int ID_W      = 11,
   parameter int DATA_W    = 32,
   parameter int MAX_RETRY = 15
) (
   input  logic                     clk,
   input  logic                     RESET,
   input  logic [NUM_MB-1:0]        mb_req,
   input  logic [NUM_MB*ID_W-1:0]   mb_id,
   input  logic [NUM_MB*DATA_W-1:0] mb_data,
   output logic [NUM_MB-1:0]        mb_pending,
   output logic [NUM_MB-1:0]        mb_done,
   output logic [NUM_MB-1:0]        mb_abort,
   output logic                     tx_start,
   output logic [ID_W-1:0]          tx_id,
   output logic [DATA_W-1:0]        tx_data,
   input  logic                     tx_busy,
   input  logic                     tx_done,
   input  logic                     tx_arb_lost,
   input  logic                     tx_error
);

   localparam int SEL_W = (NUM_MB <= 2) ? 1 : $clog2(NUM_MB);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SELECT = 2'd1;
   localparam logic [1:0] ST_LAUNCH = 2'd2;
   localparam logic [1:0] ST_WAIT   = 2'd3;

   if (NUM_MB < 2 || NUM_MB > 8 || MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_param_check
      $error("can_tx_scheduler: NUM_MB must be 2..8 and MAX_RETRY 1..15");
   end

   logic [1:0]        state_q, state_d;
   logic [NUM_MB-1:0] pending_q, pending_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [ID_W-1:0]   tx_id_q, tx_id_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic [ID_W-1:0]   id_q   [NUM_MB];
   logic [DATA_W-1:0] data_q [NUM_MB];

   logic              found;
   logic [SEL_W-1:0]  best_idx;
   logic [ID_W-1:0]   best_id;
   logic [NUM_MB-1:0] sel_oh;
   logic              in_wait;
   logic              ok;
   logic              fail;
   logic              limit_hit;

   // Lowest-ID search over pending mailboxes; strict less-than keeps the lower index on ties.
   always_comb begin
      found    = 1'b0;
      best_idx = '0;
      best_id  = '0;
      for (int unsigned i = 0; i < NUM_MB; i++) begin
         if (pending_q[i] && (!found || id_q[i] < best_id)) begin
            found    = 1'b1;
            best_idx = SEL_W'(i);
            best_id  = id_q[i];
         end
      end
   end

   // Outcome decode for the frame in flight; reset masks any outcome arriving with it.
   always_comb begin
      sel_oh        = '0;
      sel_oh[sel_q] = 1'b1;
      in_wait       = (state_q == ST_WAIT) && !RESET;
      ok            = in_wait && tx_done;
      fail          = in_wait && !tx_done && (tx_error || tx_arb_lost);
   end

`ifdef CAN_TXSCHED_RETRY_LIMIT_EN
   localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

   logic [3:0] retry_q [NUM_MB];
   logic [3:0] retry_inc;

   // Saturating attempt count for the selected mailbox and abort decision.
   always_comb begin
      retry_inc = (retry_q[sel_q] == 4'hF) ? 4'hF : retry_q[sel_q] + 4'd1;
      limit_hit = fail && (retry_inc >= RETRY_MAX);
   end

   // Per-mailbox retry counters: cleared on success/abort, bumped on failure.
   always_ff @(posedge clk) begin
      if (RESET) begin
         for (int unsigned i = 0; i < NUM_MB; i++) retry_q[i] <= '0;
      end else if (ok || limit_hit) begin
         retry_q[sel_q] <= '0;
      end else if (fail) begin
         retry_q[sel_q] <= retry_inc;
      end
   end
`else
   assign limit_hit = 1'b0;
`endif

   // Mealy completion pulses so that pending is still set during the pulse cycle.
   always_comb begin
      mb_done  = ok        ? sel_oh : '0;
      mb_abort = limit_hit ? sel_oh : '0;
   end

   // Next-state logic for the scheduler FSM, pending flags and launch registers.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      sel_d     = sel_q;
      tx_id_d   = tx_id_q;
      tx_data_d = tx_data_q;
      for (int unsigned i = 0; i < NUM_MB; i++) begin
         if (mb_req[i] && !pending_q[i]) pending_d[i] = 1'b1;
      end
      if (ok || limit_hit) pending_d[sel_q] = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((|pending_q) && !tx_busy) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            sel_d     = best_idx;
            tx_id_d   = best_id;
            tx_data_d = data_q[best_idx];
            state_d   = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            state_d = ST_WAIT;
         end
         default: begin
            if (ok || fail) state_d = ST_IDLE;
         end
      endcase
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         sel_q     <= '0;
         tx_id_q   <= '0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         sel_q     <= sel_d;
         tx_id_q   <= tx_id_d;
         tx_data_q <= tx_data_d;
      end
   end

   // Mailbox storage: captured only when a post is accepted, so pending slots never change.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_MB; i++) begin
         if (mb_req[i] && !pending_q[i]) begin
            id_q[i]   <= mb_id[i*ID_W +: ID_W];
            data_q[i] <= mb_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign mb_pending = pending_q;
   assign tx_start   = (state_q == ST_LAUNCH);
   assign tx_id      = tx_id_q;
   assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed testbench for can_tx_scheduler; covers the default build and, when
// CAN_TXSCHED_RETRY_LIMIT_EN is defined, the retry-limit abort path.
module tb_can_tx_scheduler;

   localparam int NUM_MB = 4;
   localparam int ID_W   = 11;
   localparam int DATA_W = 32;
`ifdef CAN_TXSCHED_RETRY_LIMIT_EN
   localparam int MAX_RETRY = 3;
`else
   localparam int MAX_RETRY = 15;
`endif

   logic                     clk;
   logic                     RESET;
   logic [NUM_MB-1:0]        mb_req;
   logic [NUM_MB*ID_W-1:0]   mb_id;
   logic [NUM_MB*DATA_W-1:0] mb_data;
   logic [NUM_MB-1:0]        mb_pending;
   logic [NUM_MB-1:0]        mb_done;
   logic [NUM_MB-1:0]        mb_abort;
   logic                     tx_start;
   logic [ID_W-1:0]          tx_id;
   logic [DATA_W-1:0]        tx_data;
   logic                     tx_busy;
   logic                     tx_done;
   logic                     tx_arb_lost;
   logic                     tx_error;

   int total = 0;
   int bad   = 0;

   can_tx_scheduler #(
      .NUM_MB(NUM_MB), .ID_W(ID_W), .DATA_W(DATA_W), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .RESET(RESET), .mb_req(mb_req), .mb_id(mb_id), .mb_data(mb_data),
      .mb_pending(mb_pending), .mb_done(mb_done), .mb_abort(mb_abort),
      .tx_start(tx_start), .tx_id(tx_id), .tx_data(tx_data), .tx_busy(tx_busy),
      .tx_done(tx_done), .tx_arb_lost(tx_arb_lost), .tx_error(tx_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mb(input int m, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
      mb_id[m*ID_W +: ID_W]       = id;
      mb_data[m*DATA_W +: DATA_W] = d;
      mb_req[m]                   = 1'b1;
   endtask

   task automatic wait_start(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (tx_start !== 1'b1 && n < 200);
   endtask

   task automatic drive_outcome(input logic d, input logic e, input logic a);
      tx_done     = d;
      tx_error    = e;
      tx_arb_lost = a;
      #1;
   endtask

   task automatic end_outcome();
      step();
      tx_done     = 1'b0;
      tx_error    = 1'b0;
      tx_arb_lost = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1; mb_req = '0; mb_id = '0; mb_data = '0;
      tx_busy = 1'b0; tx_done = 1'b0; tx_arb_lost = 1'b0; tx_error = 1'b0;
      step(); step();
      RESET = 1'b0;
      #1;
      total++;
      if ({mb_pending, mb_done, mb_abort, tx_start} !== '0) begin
         bad++; $display("FAIL reset_ctrl got=%h exp=0", {mb_pending, mb_done, mb_abort, tx_start});
      end
      total++;
      if ({tx_id, tx_data} !== '0) begin
         bad++; $display("FAIL reset_tx got id=%h data=%h exp 0", tx_id, tx_data);
      end
   endtask

   task automatic test_single();
      int n;
      int starts;
      set_mb(0, 11'h025, 32'hA5A5A5A5);
      step(); mb_req = '0;
      total++; if (mb_pending !== 4'b0001) begin bad++; $display("FAIL single_pending got=%b exp=0001", mb_pending); end
      wait_start(n);
      total++; if (n !== 2) begin bad++; $display("FAIL single_latency got=%0d exp=2", n); end
      total++; if (tx_id !== 11'h025) begin bad++; $display("FAIL single_id got=%h exp=025", tx_id); end
      total++; if (tx_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL single_data got=%h exp=a5a5a5a5", tx_data); end
      step();
      total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_width got=%b exp=0", tx_start); end
      // repost to mailbox 0 in the same cycle as its done pulse: must be ignored
      set_mb(0, 11'h3AA, 32'hDEAD0000);
      drive_outcome(1'b1, 1'b0, 1'b0);
      total++; if (mb_done !== 4'b0001) begin bad++; $display("FAIL single_done got=%b exp=0001", mb_done); end
      total++; if (mb_pending !== 4'b0001) begin bad++; $display("FAIL single_pend_in_done got=%b exp=0001", mb_pending); end
      end_outcome(); mb_req = '0;
      total++; if ({mb_pending, mb_done} !== 8'h00) begin bad++; $display("FAIL single_cleared got=%h exp=00", {mb_pending, mb_done}); end
      starts = 0;
      for (int k = 0; k < 6; k++) begin step(); if (tx_start === 1'b1) starts++; end
      total++; if (starts !== 0) begin bad++; $display("FAIL collision_ignored starts=%0d exp=0", starts); end
      total++; if (tx_id !== 11'h025) begin bad++; $display("FAIL idle_hold_id got=%h exp=025", tx_id); end
   endtask

   task automatic test_priority_order();
      int n;
      set_mb(1, 11'h100, 32'h11111111);
      set_mb(3, 11'h010, 32'h33333333);
      set_mb(2, 11'h010, 32'h22222222);
      step(); mb_req = '0;
      wait_start(n);
      total++; if (n !== 2 || tx_id !== 11'h010 || tx_data !== 32'h22222222) begin
         bad++; $display("FAIL order_first n=%0d id=%h data=%h exp 2/010/22222222", n, tx_id, tx_data);
      end
      step();
      // mailbox 1 is pending: this post must not overwrite it
      set_mb(1, 11'h001, 32'hBADBAD00);
      step(); mb_req = '0;
      drive_outcome(1'b1, 1'b0, 1'b0);
      total++; if (mb_done !== 4'b0100) begin bad++; $display("FAIL order_done2 got=%b exp=0100", mb_done); end
      end_outcome();
      wait_start(n);
      total++; if (n !== 2 || tx_id !== 11'h010 || tx_data !== 32'h33333333) begin
         bad++; $display("FAIL order_second n=%0d id=%h data=%h exp 2/010/33333333", n, tx_id, tx_data);
      end
      step();
      drive_outcome(1'b1, 1'b0, 1'b0);
      total++; if (mb_done !== 4'b1000) begin bad++; $display("FAIL order_done3 got=%b exp=1000", mb_done); end
      end_outcome();
      wait_start(n);
      total++; if (n !== 2 || tx_id !== 11'h100 || tx_data !== 32'h11111111) begin
         bad++; $display("FAIL order_third n=%0d id=%h data=%h exp 2/100/11111111", n, tx_id, tx_data);
      end
      step();
      drive_outcome(1'b1, 1'b0, 1'b0);
      total++; if (mb_done !== 4'b0010) begin bad++; $display("FAIL order_done1 got=%b exp=0010", mb_done); end
      end_outcome();
      total++; if (mb_pending !== 4'b0000) begin bad++; $display("FAIL order_empty got=%b exp=0000", mb_pending); end
   endtask

   task automatic test_arb_lost();
      int n;
      set_mb(0, 11'h025, 32'h12345678);
      step(); mb_req = '0;
      wait_start(n);
      step();
      drive_outcome(1'b0, 1'b0, 1'b1);
      total++; if ({mb_done, mb_abort} !== 8'h00) begin bad++; $display("FAIL arb_no_pulse got=%h exp=00", {mb_done, mb_abort}); end
      end_outcome();
      total++; if (mb_pending !== 4'b0001) begin bad++; $display("FAIL arb_still_pending got=%b exp=0001", mb_pending); end
      wait_start(n);
      total++; if (n !== 2 || tx_id !== 11'h025 || tx_data !== 32'h12345678) begin
         bad++; $display("FAIL arb_relaunch n=%0d id=%h data=%h exp 2/025/12345678", n, tx_id, tx_data);
      end
      step();
      // all three outcomes together: done takes precedence
      drive_outcome(1'b1, 1'b1, 1'b1);
      total++; if (mb_done !== 4'b0001 || mb_abort !== 4'b0000) begin
         bad++; $display("FAIL outcome_priority done=%b abort=%b exp 0001/0000", mb_done, mb_abort);
      end
      end_outcome();
      total++; if (mb_pending !== 4'b0000) begin bad++; $display("FAIL outcome_priority_pend got=%b exp=0000", mb_pending); end
   endtask

   task automatic test_ignore_outside_wait();
      int errs;
      errs = 0;
      set_mb(2, 11'h123, 32'h0F0F0F0F);
      step(); mb_req = '0;
      tx_done = 1'b1; tx_error = 1'b1;
      #1;
      if (mb_done !== 4'b0000 || mb_abort !== 4'b0000) errs++;
      step();
      if (mb_done !== 4'b0000 || mb_abort !== 4'b0000) errs++;
      step();
      if (mb_done !== 4'b0000 || mb_abort !== 4'b0000 || tx_start !== 1'b1) errs++;
      tx_done = 1'b0; tx_error = 1'b0;
      total++; if (errs !== 0) begin bad++; $display("FAIL outside_wait_pulses errs=%0d exp=0", errs); end
      total++; if (mb_pending !== 4'b0100) begin bad++; $display("FAIL outside_wait_pending got=%b exp=0100", mb_pending); end
      step();
      drive_outcome(1'b1, 1'b0, 1'b0);
      total++; if (mb_done !== 4'b0100) begin bad++; $display("FAIL outside_wait_done got=%b exp=0100", mb_done); end
      end_outcome();
   endtask

   task automatic test_retry();
      int n;
      logic [NUM_MB-1:0] exp_abort;
      set_mb(0, 11'h055, 32'hCAFEF00D);
      step(); mb_req = '0;
      for (int a = 1; a <= 3; a++) begin
         wait_start(n);
         total++; if (n !== 2 || tx_id !== 11'h055) begin bad++; $display("FAIL retry_start%0d n=%0d id=%h exp 2/055", a, n, tx_id); end
         step();
         drive_outcome(1'b0, 1'b1, 1'b0);
`ifdef CAN_TXSCHED_RETRY_LIMIT_EN
         exp_abort = (a == 3) ? 4'b0001 : 4'b0000;
`else
         exp_abort = 4'b0000;
`endif
         total++; if (mb_abort !== exp_abort || mb_done !== 4'b0000) begin
            bad++; $display("FAIL retry_err%0d abort=%b done=%b exp %b/0000", a, mb_abort, mb_done, exp_abort);
         end
         end_outcome();
      end
`ifdef CAN_TXSCHED_RETRY_LIMIT_EN
      total++; if (mb_pending !== 4'b0000) begin bad++; $display("FAIL retry_abort_pend got=%b exp=0000", mb_pending); end
      n = 0;
      for (int k = 0; k < 10; k++) begin step(); if (tx_start === 1'b1) n++; end
      total++; if (n !== 0) begin bad++; $display("FAIL retry_no_4th starts=%0d exp=0", n); end
`else
      wait_start(n);
      total++; if (n !== 2 || tx_id !== 11'h055 || tx_data !== 32'hCAFEF00D) begin
         bad++; $display("FAIL retry_4th n=%0d id=%h data=%h exp 2/055/cafef00d", n, tx_id, tx_data);
      end
      step();
      drive_outcome(1'b1, 1'b0, 1'b0);
      total++; if (mb_done !== 4'b0001) begin bad++; $display("FAIL retry_final_done got=%b exp=0001", mb_done); end
      end_outcome();
`endif
   endtask

   task automatic test_reset_mid_frame();
      int n;
      set_mb(0, 11'h050, 32'h00000050);
      set_mb(1, 11'h040, 32'h00000040);
      set_mb(2, 11'h060, 32'h00000060);
      step(); mb_req = '0;
      wait_start(n);
      total++; if (tx_id !== 11'h040) begin bad++; $display("FAIL rst_mid_launch id=%h exp=040", tx_id); end
      step();
      RESET = 1'b1;
      drive_outcome(1'b1, 1'b0, 1'b0);
      total++; if ({mb_done, mb_abort} !== 8'h00) begin bad++; $display("FAIL rst_mid_pulse got=%h exp=00", {mb_done, mb_abort}); end
      end_outcome();
      total++; if ({mb_pending, tx_start, mb_done, mb_abort} !== '0) begin
         bad++; $display("FAIL rst_mid_clear got=%h exp=0", {mb_pending, tx_start, mb_done, mb_abort});
      end
      RESET = 1'b0;
      n = 0;
      for (int k = 0; k < 10; k++) begin step(); if (tx_start === 1'b1) n++; end
      total++; if (n !== 0) begin bad++; $display("FAIL rst_mid_quiet starts=%0d exp=0", n); end
   endtask

   task automatic test_busy();
      int n;
      int starts;
      tx_busy = 1'b1;
      set_mb(3, 11'h7FF, 32'h55AA55AA);
      step(); mb_req = '0;
      starts = 0;
      for (int k = 0; k < 50; k++) begin step(); if (tx_start === 1'b1) starts++; end
      total++; if (starts !== 0) begin bad++; $display("FAIL busy_hold starts=%0d exp=0", starts); end
      tx_busy = 1'b0;
      wait_start(n);
      total++; if (n !== 2 || tx_id !== 11'h7FF) begin bad++; $display("FAIL busy_release n=%0d id=%h exp 2/7ff", n, tx_id); end
      step();
      drive_outcome(1'b1, 1'b0, 1'b0);
      total++; if (mb_done !== 4'b1000) begin bad++; $display("FAIL busy_done got=%b exp=1000", mb_done); end
      end_outcome();
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority_order();
      test_arb_lost();
      test_ignore_outside_wait();
      test_retry();
      test_reset_mid_frame();
      test_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
